memory_unit: RTL and testbench

Sequencer between the pipelined core's memory ports and a single shared memory bus. Each pipeline step it fetches one instruction and performs at most one data access. It aligns store data and byte lanes, and aligns and sign- or zero-extends load data. It drives `mem_busy` to hold every pipeline register until both accesses have completed.

---
 rtl/memory_unit_pkg.sv | 16 +
 rtl/load_store_aligner.sv | 42 ++++
 rtl/memory_unit.sv | 139 +++++++++++++
 tb/tb_memory_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_unit_pkg.sv
// Shared types and constants for the memory_unit sequencer and its aligner.
package memory_unit_pkg;

  typedef enum logic [1:0] {
    Fetch,
    Data,
    Done
  } mem_unit_state_t;

  localparam logic [31:0] NopInstruction = 32'h00000013;

  function automatic int offset_width(input int data_size);
    return $clog2(data_size / 8);
  endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Combinational lane steering: store data/byte-enable shifting, load shift,
// size masking and sign/zero extension.
module load_store_aligner
  import memory_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int OW        = offset_width(DATA_SIZE)
) (
  input  logic [OW-1:0]          i_offset,
  input  logic [DATA_SIZE/8-1:0] i_byte_en,
  input  logic                   i_mem_signed,
  input  logic [DATA_SIZE-1:0]   i_wr_data,
  input  logic [DATA_SIZE-1:0]   i_bus_rd_data,
  output logic [DATA_SIZE/8-1:0] o_bus_sel,
  output logic [DATA_SIZE-1:0]   o_bus_wr_data,
  output logic [DATA_SIZE-1:0]   o_rd_data
);

  localparam int NB = DATA_SIZE / 8;
  localparam int CW = $clog2(NB) + 1;

  logic [DATA_SIZE-1:0] w_shifted;
  logic [CW-1:0]        w_cnt;
  logic                 w_ext;

  always_comb begin
    // Lanes pushed past the bus width fall off the top.
    o_bus_sel     = i_byte_en << i_offset;
    o_bus_wr_data = i_wr_data << {i_offset, 3'b000};
    w_shifted     = i_bus_rd_data >> {i_offset, 3'b000};
    w_cnt = '0;
    for (int i = 0; i < NB; i++) w_cnt = w_cnt + CW'(i_byte_en[i]);
    w_ext = 1'b0;
    for (int i = 0; i < NB; i++)
      if (int'(w_cnt) == i + 1) w_ext = w_shifted[8*i+7];
    w_ext = w_ext & i_mem_signed;
    o_rd_data = '0;
    for (int i = 0; i < NB; i++)
      o_rd_data[8*i +: 8] = (i < int'(w_cnt)) ? w_shifted[8*i +: 8] : {8{w_ext}};
  end

endmodule

// File: rtl/memory_unit.sv
// Fetch/data sequencer onto one shared bus; stalls the core via mem_busy.
// Optional one-entry instruction buffer: MEMORY_UNIT_INST_BUFFER_EN.
module memory_unit
  import memory_unit_pkg::*;
#(
  parameter int DATA_SIZE = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   inst_mem_addr,
  output logic [31:0]            inst,
  input  logic                   rd_en,
  input  logic                   wr_en,
  input  logic [DATA_SIZE/8-1:0] mem_byte_en,
  input  logic                   mem_signed,
  input  logic [DATA_SIZE-1:0]   data_mem_addr,
  input  logic [DATA_SIZE-1:0]   wr_data,
  output logic [DATA_SIZE-1:0]   rd_data,
  output logic                   mem_busy,
  output logic                   bus_stb,
  output logic                   bus_we,
  output logic [DATA_SIZE-1:0]   bus_addr,
  output logic [DATA_SIZE/8-1:0] bus_sel,
  output logic [DATA_SIZE-1:0]   bus_wr_data,
  input  logic [DATA_SIZE-1:0]   bus_rd_data,
  input  logic                   bus_ack
);

  localparam int NB = DATA_SIZE / 8;
  localparam int OW = offset_width(DATA_SIZE);
  localparam logic [DATA_SIZE-1:0] AlignMask = ~DATA_SIZE'(NB - 1);

  mem_unit_state_t      r_state, w_next;
  logic [31:0]          r_inst;
  logic [DATA_SIZE-1:0] r_rd_data;
  logic [NB-1:0]        w_sel;
  logic [DATA_SIZE-1:0] w_wr_shift, w_rd_ext;
  logic [31:0]          w_fetch_word, w_buf_inst;
  logic                 w_buf_hit;
  logic                 w_unused_pc;

  assign w_unused_pc = ^inst_mem_addr[1:0];

  load_store_aligner #(.DATA_SIZE(DATA_SIZE), .OW(OW)) u_aligner (
    .i_offset     (data_mem_addr[OW-1:0]),
    .i_byte_en    (mem_byte_en),
    .i_mem_signed (mem_signed),
    .i_wr_data    (wr_data),
    .i_bus_rd_data(bus_rd_data),
    .o_bus_sel    (w_sel),
    .o_bus_wr_data(w_wr_shift),
    .o_rd_data    (w_rd_ext)
  );

  generate
    if (DATA_SIZE == 64) begin : g_w64
      assign w_fetch_word = inst_mem_addr[2] ? bus_rd_data[DATA_SIZE-1 -: 32] : bus_rd_data[31:0];
    end else begin : g_w32
      assign w_fetch_word = bus_rd_data[31:0];
    end
  endgenerate

`ifdef MEMORY_UNIT_INST_BUFFER_EN
  logic                 r_buf_vld;
  logic [DATA_SIZE-3:0] r_buf_waddr;
  logic [31:0]          r_buf_inst;

  assign w_buf_hit  = r_buf_vld && (r_buf_waddr == inst_mem_addr[DATA_SIZE-1:2]);
  assign w_buf_inst = r_buf_inst;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_buf_vld   <= 1'b0;
      r_buf_waddr <= '0;
      r_buf_inst  <= NopInstruction;
    end else if (r_state == Fetch && !w_buf_hit && bus_ack) begin
      r_buf_vld   <= 1'b1;
      r_buf_waddr <= inst_mem_addr[DATA_SIZE-1:2];
      r_buf_inst  <= w_fetch_word;
    end else if (r_state == Data && bus_ack && wr_en &&
                 r_buf_waddr == data_mem_addr[DATA_SIZE-1:2]) begin
      // A store over the buffered word makes the copy stale.
      r_buf_vld <= 1'b0;
    end
  end
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_inst = NopInstruction;
`endif

  always_comb begin
    w_next      = r_state;
    bus_stb     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_sel     = '0;
    bus_wr_data = '0;
    case (r_state)
      Fetch: begin
        bus_stb  = ~w_buf_hit;
        bus_sel  = '1;
        bus_addr = inst_mem_addr & AlignMask;
        if (w_buf_hit || bus_ack) w_next = (rd_en | wr_en) ? Data : Done;
      end
      Data: begin
        bus_stb     = 1'b1;
        bus_we      = wr_en;
        bus_addr    = data_mem_addr & AlignMask;
        bus_sel     = w_sel;
        bus_wr_data = w_wr_shift;
        if (bus_ack) w_next = Done;
      end
      Done:    w_next = Fetch;
      default: w_next = Fetch;
    endcase
    // State already sits in Fetch during reset; keep the strobe quiet until release.
    bus_stb = bus_stb & reset;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= Fetch;
      r_inst    <= NopInstruction;
      r_rd_data <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == Fetch) begin
        if (w_buf_hit)    r_inst <= w_buf_inst;
        else if (bus_ack) r_inst <= w_fetch_word;
      end
      if (r_state == Data && bus_ack && rd_en && !wr_en) r_rd_data <= w_rd_ext;
    end
  end

  assign mem_busy = (r_state != Done);
  assign inst     = r_inst;
  assign rd_data  = r_rd_data;

endmodule

// File: tb/tb_memory_unit.sv
// Directed bench for memory_unit (DATA_SIZE=32) against a small wait-state bus model.
module tb_memory_unit;

  localparam int DS = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DS-1:0] inst_mem_addr, data_mem_addr, wr_data, rd_data;
  logic [31:0]   inst;
  logic          rd_en, wr_en, mem_signed, mem_busy;
  logic [3:0]    mem_byte_en, bus_sel;
  logic          bus_stb, bus_we, bus_ack;
  logic [DS-1:0] bus_addr, bus_wr_data, bus_rd_data;

  logic [31:0] mem [0:255];
  logic [31:0] delay_addr;
  int          delay_n;
  int          wcnt = 0;
  int          n_chk = 0;
  int          n_err = 0;

  memory_unit #(.DATA_SIZE(DS)) dut (
    .clock(clock), .reset(reset), .inst_mem_addr(inst_mem_addr), .inst(inst),
    .rd_en(rd_en), .wr_en(wr_en), .mem_byte_en(mem_byte_en), .mem_signed(mem_signed),
    .data_mem_addr(data_mem_addr), .wr_data(wr_data), .rd_data(rd_data),
    .mem_busy(mem_busy), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
    .bus_ack(bus_ack)
  );

  always #5 clock = ~clock;

  // Slave acks after delay_n wait states for delay_addr, zero-wait elsewhere.
  assign bus_ack     = bus_stb && (wcnt >= ((bus_addr == delay_addr) ? delay_n : 0));
  assign bus_rd_data = mem[bus_addr[9:2]];

  always @(posedge clock or negedge reset)
    if (!reset) wcnt <= 0;
    else if (bus_stb && !bus_ack) wcnt <= wcnt + 1;
    else wcnt <= 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic setup(input logic [31:0] pc, input logic rd, input logic wr,
                       input logic [3:0] be, input logic sgn,
                       input logic [31:0] da, input logic [31:0] wd);
    inst_mem_addr = pc; rd_en = rd; wr_en = wr; mem_byte_en = be;
    mem_signed = sgn; data_mem_addr = da; wr_data = wd;
  endtask

  // Runs one pipeline step (Fetch -> ... -> Done), starting just after a posedge.
  task automatic do_step(output int cyc, output int stb_cyc, output logic we,
                         output logic [3:0] sel, output logic [31:0] wd,
                         output logic [31:0] adr, output logic unstable);
    logic        pend;
    logic [68:0] prev, cur;
    cyc = 0; stb_cyc = 0; unstable = 1'b0; pend = 1'b0;
    we = 1'b0; sel = '0; wd = '0; adr = '0; prev = '0;
    forever begin
      @(negedge clock);
      cyc++;
      if (bus_stb) begin
        stb_cyc++;
        cur = {bus_we, bus_sel, bus_wr_data, bus_addr};
        if (pend && cur !== prev) unstable = 1'b1;
        prev = cur; pend = !bus_ack;
        we = bus_we; sel = bus_sel; wd = bus_wr_data; adr = bus_addr;
      end else pend = 1'b0;
      if (!mem_busy) break;
      if (cyc >= 40) begin
        chk("step_timeout_busy", mem_busy, 0);
        break;
      end
    end
    @(posedge clock); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, stb_cyc;
    logic        we, unstable;
    logic [3:0]  sel;
    logic [31:0] wd, adr;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h00] = 32'h00500093;
    mem[8'h04] = 32'h00100113;
    mem[8'h08] = 32'h002081b3;
    mem[8'h40] = 32'h80112233;
    mem[8'h80] = 32'h12345678;
    mem[8'hC0] = 32'h0000F0A5;
    delay_addr = 32'hFFFF_FFFF; delay_n = 0;
    setup(32'h0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);

    // Reset state
    #12;
    chk("rst_busy", mem_busy, 1);
    chk("rst_stb", bus_stb, 0);
    chk("rst_inst", inst, 32'h00000013);
    chk("rst_rd_data", rd_data, 0);
    @(posedge clock); #2 reset = 1'b1;

    // First step after reset, no data access: busy 1,0,1,0
    @(negedge clock);
    chk("s0_busy0", mem_busy, 1);
    chk("s0_stb", bus_stb, 1);
    chk("s0_addr", bus_addr, 0);
    chk("s0_inst_pre_ack", inst, 32'h00000013);
    @(negedge clock);
    chk("s0_busy1", mem_busy, 0);
    chk("s0_inst", inst, 32'h00500093);
    @(negedge clock);
    chk("s0_busy2", mem_busy, 1);
    @(negedge clock);
    chk("s0_busy3", mem_busy, 0);
    @(posedge clock); #1;

    // Load byte signed / unsigned at 0x103
    setup(32'h10, 1'b1, 1'b0, 4'h1, 1'b1, 32'h103, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("lb_cycles", cyc, 3);
    chk("lb_sel", sel, 4'b1000);
    chk("lb_addr", adr, 32'h100);
    chk("lb_we", we, 0);
    chk("lb_signed", rd_data, 32'hFFFFFF80);
    chk("lb_inst", inst, 32'h00100113);
    setup(32'h10, 1'b1, 1'b0, 4'h1, 1'b0, 32'h103, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("lbu_data", rd_data, 32'h00000080);

    // Load half signed at 0x102, word at 0x100
    setup(32'h10, 1'b1, 1'b0, 4'h3, 1'b1, 32'h102, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("lh_sel", sel, 4'b1100);
    chk("lh_signed", rd_data, 32'hFFFF8011);
    setup(32'h10, 1'b1, 1'b0, 4'hF, 1'b1, 32'h100, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("lw_data", rd_data, 32'h80112233);

    // Stores: rd_data must keep the last load
    setup(32'h10, 1'b0, 1'b1, 4'h3, 1'b0, 32'h202, 32'h0000ABCD);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("sh_cycles", cyc, 3);
    chk("sh_we", we, 1);
    chk("sh_sel", sel, 4'b1100);
    chk("sh_wdata", wd, 32'hABCD0000);
    chk("sh_addr", adr, 32'h200);
    chk("sh_rd_keep", rd_data, 32'h80112233);
    setup(32'h10, 1'b0, 1'b1, 4'h1, 1'b0, 32'h201, 32'h0000005A);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("sb_sel", sel, 4'b0010);
    chk("sb_wdata", wd, 32'h00005A00);
    setup(32'h10, 1'b1, 1'b1, 4'hF, 1'b0, 32'h100, 32'h11112222);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("rw_we", we, 1);
    chk("rw_wdata", wd, 32'h11112222);
    chk("rw_rd_keep", rd_data, 32'h80112233);

    // Step with no data access
    setup(32'h20, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("nd_cycles", cyc, 2);
    chk("nd_inst", inst, 32'h002081b3);

    // Data access with 3 wait states
    delay_addr = 32'h300; delay_n = 3;
    setup(32'h0, 1'b1, 1'b0, 4'h3, 1'b0, 32'h300, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("dly_cycles", cyc, 6);
    chk("dly_stb_cycles", stb_cyc, 5);
    chk("dly_stable", unstable, 0);
    chk("dly_data", rd_data, 32'h0000F0A5);
    chk("dly_inst", inst, 32'h00500093);

    // Reset in the middle of a stalled data request
    delay_n = 20;
    setup(32'h10, 1'b1, 1'b0, 4'hF, 1'b0, 32'h300, 32'h0);
    @(negedge clock);
    @(negedge clock);
    chk("mid_stb_before", bus_stb, 1);
    chk("mid_addr_before", bus_addr, 32'h300);
    #2 reset = 1'b0;
    #1;
    chk("mid_stb_drop", bus_stb, 0);
    chk("mid_busy", mem_busy, 1);
    chk("mid_rd_data", rd_data, 0);
    chk("mid_inst", inst, 32'h00000013);
    @(posedge clock); #2;
    delay_n = 0;
    setup(32'h20, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    chk("post_rst_stb", bus_stb, 1);
    chk("post_rst_addr", bus_addr, 32'h20);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("post_rst_cycles", cyc, 2);
    chk("post_rst_inst", inst, 32'h002081b3);

`ifdef MEMORY_UNIT_INST_BUFFER_EN
    // Same PC again is served from the buffer; a store to it forces a refetch
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("buf_hit_stb", stb_cyc, 0);
    chk("buf_hit_cycles", cyc, 2);
    chk("buf_hit_inst", inst, 32'h002081b3);
    setup(32'h20, 1'b0, 1'b1, 4'hF, 1'b0, 32'h20, 32'hDEAD0000);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("buf_st_stb", stb_cyc, 1);
    setup(32'h20, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0, 32'h0);
    do_step(cyc, stb_cyc, we, sel, wd, adr, unstable);
    chk("buf_inval_stb", stb_cyc, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
